// File: rtl/store_queue_pkg.sv
// Shared types and constants for the store queue and its formatter.
// Geometry: 16 vector lanes, 64-byte cache lines, 4 hardware threads.
package store_queue_pkg;

    localparam int NUM_THREADS               = 4;
    localparam int VECTOR_LANES              = 16;
    localparam int CACHE_LINE_BYTES          = 64;
    localparam int CACHE_LINE_BITS           = CACHE_LINE_BYTES * 8;
    localparam int CACHE_LINE_OFFSET         = $clog2(CACHE_LINE_BYTES);
    localparam int DEFAULT_STORE_QUEUE_DEPTH = 4;

    typedef logic [$clog2(NUM_THREADS)-1:0]   thread_idx_t;
    typedef logic [31:0]                      scalar_t;
    typedef logic [VECTOR_LANES*32-1:0]       vector_t;
    typedef logic [VECTOR_LANES-1:0]          vector_mask_t;
    typedef logic [31-CACHE_LINE_OFFSET:0]    l2_line_addr_t;
    typedef logic [CACHE_LINE_BITS-1:0]       cache_line_data_t;
    typedef logic [CACHE_LINE_BYTES-1:0]      cache_line_byte_en_t;

    typedef enum logic [3:0] {
        MEM_B           = 4'd0,
        MEM_BX          = 4'd1,
        MEM_S           = 4'd2,
        MEM_SX          = 4'd3,
        MEM_L           = 4'd4,
        MEM_SYNC        = 4'd5,
        MEM_CONTROL_REG = 4'd6,
        MEM_BLOCK       = 4'd7,
        MEM_BLOCK_M     = 4'd8,
        MEM_BLOCK_IM    = 4'd9,
        MEM_SCGATH      = 4'd10,
        MEM_SCGATH_M    = 4'd11,
        MEM_SCGATH_IM   = 4'd12
    } fmtc_op_t;

    typedef struct packed {
        thread_idx_t         thread_idx;
        l2_line_addr_t       line_addr;
        cache_line_data_t    data;
        cache_line_byte_en_t byte_en;
    } store_queue_entry_t;

    // Widen a per-byte enable into a per-bit mask over the line.
    function automatic cache_line_data_t expand_byte_en(input cache_line_byte_en_t en);
        cache_line_data_t mask;
        for (int i = 0; i < CACHE_LINE_BYTES; i++)
            mask[i*8 +: 8] = {8{en[i]}};
        return mask;
    endfunction

endpackage

// File: rtl/store_queue_formatter.sv
// store_formatter: converts one store request into line-aligned write data and
// byte enables (inverse of the load aligner / block endian swap).
// Ports:
//   request_addr  byte address of the store
//   store_op      memory access type
//   store_value   store data, lane 0 for scalar stores
//   store_mask    per-lane enable for block stores
//   line_data     data placed in line layout (byte at offset o in bits (63-o)*8)
//   byte_en       per-byte enables in the same layout
//   legal         op is a store type and the address is suitably aligned
module store_formatter
    import store_queue_pkg::*;
(
    input  scalar_t             request_addr,
    input  fmtc_op_t            store_op,
    input  vector_t             store_value,
    input  vector_mask_t        store_mask,
    output cache_line_data_t    line_data,
    output cache_line_byte_en_t byte_en,
    output logic                legal
);

    logic [CACHE_LINE_OFFSET-1:0] line_offset;
    logic [CACHE_LINE_OFFSET-1:0] byte_idx;

    assign line_offset = request_addr[CACHE_LINE_OFFSET-1:0];
    // Lowest address sits in the most significant byte of the line.
    assign byte_idx = ~line_offset;

    always_comb begin
        line_data = '0;
        byte_en   = '0;
        legal     = 1'b0;
        case (store_op)
            MEM_B, MEM_BX: begin
                legal = 1'b1;
                line_data[byte_idx*8 +: 8] = store_value[7:0];
                byte_en[byte_idx] = 1'b1;
            end
            MEM_S, MEM_SX: begin
                if (!request_addr[0]) begin
                    legal = 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        line_data[(byte_idx - i)*8 +: 8] = store_value[i*8 +: 8];
                        byte_en[byte_idx - i] = 1'b1;
                    end
                end
            end
            MEM_L: begin
                if (request_addr[1:0] == 2'b00) begin
                    legal = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        line_data[(byte_idx - i)*8 +: 8] = store_value[i*8 +: 8];
                        byte_en[byte_idx - i] = 1'b1;
                    end
                end
            end
            MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM: begin
                if (line_offset == '0) begin
                    legal = 1'b1;
                    // Each lane is byte-swapped; lane 0 ends up at the highest address.
                    for (int lane = 0; lane < VECTOR_LANES; lane++) begin
                        line_data[lane*32 +: 32] = {store_value[lane*32      +: 8],
                                                    store_value[lane*32 + 8  +: 8],
                                                    store_value[lane*32 + 16 +: 8],
                                                    store_value[lane*32 + 24 +: 8]};
                        byte_en[lane*4 +: 4] = {4{store_mask[lane]}};
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/store_queue.sv
// store_queue: formats dcache stores into line writes, buffers them in a small
// circular FIFO that merges same-line/same-thread stores into its youngest
// entry, and issues the head to L2 with valid/ready. A store that finds the
// queue full (and no dequeue this cycle) is rejected with a rollback request.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   dd_*                       store request from the dcache data stage
//   sq_rollback_*              rejection (combinational), thread and restart PC
//   sq_l2_req_*                head entry toward L2, l2_sq_req_ready accepts it
//   sq_empty                   queue holds nothing (membar drain)
module store_queue
    import store_queue_pkg::*;
#(
    parameter int STORE_QUEUE_DEPTH = DEFAULT_STORE_QUEUE_DEPTH  // power of two, >= 2
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                dd_store_en,
    input  thread_idx_t         dd_thread_idx,
    input  scalar_t             dd_store_pc,
    input  scalar_t             dd_request_addr,
    input  fmtc_op_t            dd_store_op,
    input  vector_t             dd_store_value,
    input  vector_mask_t        dd_store_mask,

    output logic                sq_rollback_en,
    output thread_idx_t         sq_rollback_thread_idx,
    output scalar_t             sq_rollback_pc,

    output logic                sq_l2_req_valid,
    output thread_idx_t         sq_l2_req_thread_idx,
    output l2_line_addr_t       sq_l2_req_line_addr,
    output cache_line_data_t    sq_l2_req_data,
    output cache_line_byte_en_t sq_l2_req_byte_en,
    input  logic                l2_sq_req_ready,

    output logic                sq_empty
);

    localparam int PTR_W = $clog2(STORE_QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(STORE_QUEUE_DEPTH);

    cache_line_data_t    fmt_data;
    cache_line_byte_en_t fmt_byte_en;
    logic                fmt_legal;
    logic                store_valid;
    l2_line_addr_t       store_line_addr;

    store_queue_entry_t  entries_q [STORE_QUEUE_DEPTH];
    store_queue_entry_t  new_entry;
    store_queue_entry_t  merged_entry;
    store_queue_entry_t  youngest;
    cache_line_data_t    new_bit_mask;

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [PTR_W-1:0]    youngest_idx;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                dequeue;
    logic                merge;
    logic                enqueue;
    logic                reject;

    store_formatter u_formatter (
        .request_addr (dd_request_addr),
        .store_op     (dd_store_op),
        .store_value  (dd_store_value),
        .store_mask   (dd_store_mask),
        .line_data    (fmt_data),
        .byte_en      (fmt_byte_en),
        .legal        (fmt_legal)
    );

    // Illegal stores are dropped silently in hardware; flag them in simulation.
    illegal_store: assert property (@(posedge clk) disable iff (reset)
        dd_store_en |-> fmt_legal);

    assign store_valid     = dd_store_en && fmt_legal;
    assign store_line_addr = dd_request_addr[31:CACHE_LINE_OFFSET];
    assign youngest_idx    = tail_q - PTR_W'(1);
    assign youngest        = entries_q[youngest_idx];
    assign new_bit_mask    = expand_byte_en(fmt_byte_en);

    always_comb begin
        new_entry.thread_idx = dd_thread_idx;
        new_entry.line_addr  = store_line_addr;
        new_entry.data       = fmt_data;
        new_entry.byte_en    = fmt_byte_en;

        merged_entry         = youngest;
        merged_entry.data    = (youngest.data & ~new_bit_mask) | (fmt_data & new_bit_mask);
        merged_entry.byte_en = youngest.byte_en | fmt_byte_en;
    end

    always_comb begin
        dequeue = (count_q != '0) && l2_sq_req_ready;
        // A lone entry that is leaving this cycle must not absorb the new store.
        merge = store_valid && (count_q != '0)
            && (youngest.line_addr == store_line_addr)
            && (youngest.thread_idx == dd_thread_idx)
            && !((count_q == CNT_W'(1)) && dequeue);
        enqueue = store_valid && !merge && ((count_q != FULL_COUNT) || dequeue);
        reject  = store_valid && !merge && (count_q == FULL_COUNT) && !dequeue;

        head_d  = dequeue ? head_q + PTR_W'(1) : head_q;
        tail_d  = enqueue ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (enqueue && !dequeue)
            count_d = count_q + CNT_W'(1);
        else if (dequeue && !enqueue)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (enqueue)
            entries_q[tail_q] <= new_entry;
        else if (merge)
            entries_q[youngest_idx] <= merged_entry;
    end

    assign sq_rollback_en         = reject;
    assign sq_rollback_thread_idx = reject ? dd_thread_idx : '0;
    assign sq_rollback_pc         = reject ? dd_store_pc : '0;

    assign sq_l2_req_valid        = (count_q != '0);
    assign sq_l2_req_thread_idx   = entries_q[head_q].thread_idx;
    assign sq_l2_req_line_addr    = entries_q[head_q].line_addr;
    assign sq_l2_req_data         = entries_q[head_q].data;
    assign sq_l2_req_byte_en      = entries_q[head_q].byte_en;
    assign sq_empty               = (count_q == '0);

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
    import store_queue_pkg::*;

    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                dd_store_en = 1'b0;
    thread_idx_t         dd_thread_idx = '0;
    scalar_t             dd_store_pc = '0;
    scalar_t             dd_request_addr = '0;
    fmtc_op_t            dd_store_op = MEM_B;
    vector_t             dd_store_value = '0;
    vector_mask_t        dd_store_mask = '0;
    logic                sq_rollback_en;
    thread_idx_t         sq_rollback_thread_idx;
    scalar_t             sq_rollback_pc;
    logic                sq_l2_req_valid;
    thread_idx_t         sq_l2_req_thread_idx;
    l2_line_addr_t       sq_l2_req_line_addr;
    cache_line_data_t    sq_l2_req_data;
    cache_line_byte_en_t sq_l2_req_byte_en;
    logic                l2_sq_req_ready = 1'b0;
    logic                sq_empty;

    always #5 clk = ~clk;

    store_queue #(.STORE_QUEUE_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .dd_store_en            (dd_store_en),
        .dd_thread_idx          (dd_thread_idx),
        .dd_store_pc            (dd_store_pc),
        .dd_request_addr        (dd_request_addr),
        .dd_store_op            (dd_store_op),
        .dd_store_value         (dd_store_value),
        .dd_store_mask          (dd_store_mask),
        .sq_rollback_en         (sq_rollback_en),
        .sq_rollback_thread_idx (sq_rollback_thread_idx),
        .sq_rollback_pc         (sq_rollback_pc),
        .sq_l2_req_valid        (sq_l2_req_valid),
        .sq_l2_req_thread_idx   (sq_l2_req_thread_idx),
        .sq_l2_req_line_addr    (sq_l2_req_line_addr),
        .sq_l2_req_data         (sq_l2_req_data),
        .sq_l2_req_byte_en      (sq_l2_req_byte_en),
        .l2_sq_req_ready        (l2_sq_req_ready),
        .sq_empty               (sq_empty)
    );

    // Reference entry, memory view: bytes[o]/en[o] indexed by line offset.
    typedef struct packed {
        logic [1:0]       thread;
        logic [25:0]      line;
        logic [63:0][7:0] bytes;
        logic [63:0]      en;
    } mentry_t;

    typedef struct packed {
        logic        valid;
        logic        rb;
        logic [1:0]  thread;
        logic [31:0] pc;
    } cyc_t;

    mentry_t model_q[$];
    mentry_t deq_q[$];
    cyc_t    cyc_q[$];
    int      tests = 0;
    int      fails = 0;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Every store writes consecutive bytes little-endian in memory; block lane L
    // is a word at offset (15-L)*4.
    function automatic mentry_t build(input logic [1:0] thr, input logic [31:0] addr,
                                      input fmtc_op_t op, input logic [511:0] value,
                                      input logic [15:0] mask);
        mentry_t e = '0;
        int o = int'(addr[5:0]);
        int n;
        e.thread = thr;
        e.line = addr[31:6];
        if (op == MEM_BLOCK || op == MEM_BLOCK_M || op == MEM_BLOCK_IM) begin
            for (int l = 0; l < 16; l++)
                if (mask[l])
                    for (int i = 0; i < 4; i++) begin
                        e.bytes[(15 - l)*4 + i] = value[l*32 + i*8 +: 8];
                        e.en[(15 - l)*4 + i] = 1'b1;
                    end
        end else begin
            n = (op == MEM_B || op == MEM_BX) ? 1 : (op == MEM_L) ? 4 : 2;
            for (int i = 0; i < n; i++) begin
                e.bytes[o + i] = value[i*8 +: 8];
                e.en[o + i] = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic to_dut(input mentry_t e, output logic [511:0] data,
                          output logic [63:0] en, output logic [511:0] bitmask);
        data = '0;
        en = '0;
        bitmask = '0;
        for (int o = 0; o < 64; o++) begin
            data[(63 - o)*8 +: 8] = e.bytes[o];
            en[63 - o] = e.en[o];
            if (e.en[o]) bitmask[(63 - o)*8 +: 8] = 8'hFF;
        end
    endtask

    // One clock cycle of stimulus; the model advances using pre-edge state.
    task automatic step(input logic en, input logic [1:0] thr, input logic [31:0] pc,
                        input logic [31:0] addr, input fmtc_op_t op,
                        input logic [511:0] value, input logic [15:0] mask, input logic rdy);
        cyc_t    c;
        mentry_t ne = '0;
        mentry_t t;
        logic    deq, merge, rej;
        @(posedge clk);
        #1;
        dd_store_en = en;
        dd_thread_idx = thr;
        dd_store_pc = pc;
        dd_request_addr = addr;
        dd_store_op = op;
        dd_store_value = value;
        dd_store_mask = mask;
        l2_sq_req_ready = rdy;

        c.valid = (model_q.size() != 0);
        deq = c.valid && rdy;
        merge = 1'b0;
        rej = 1'b0;
        if (en) begin
            ne = build(thr, addr, op, value, mask);
            merge = (model_q.size() != 0) && (model_q[model_q.size()-1].line == ne.line)
                && (model_q[model_q.size()-1].thread == thr)
                && !(model_q.size() == 1 && deq);
            rej = !merge && (model_q.size() == DEPTH) && !deq;
        end
        c.rb = rej;
        c.thread = rej ? thr : 2'd0;
        c.pc = rej ? pc : 32'd0;
        cyc_q.push_back(c);
        if (deq) deq_q.push_back(model_q.pop_front());
        if (en) begin
            if (merge) begin
                t = model_q[model_q.size()-1];
                for (int o = 0; o < 64; o++)
                    if (ne.en[o]) t.bytes[o] = ne.bytes[o];
                t.en = t.en | ne.en;
                model_q[model_q.size()-1] = t;
            end else if (!rej) begin
                model_q.push_back(ne);
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 2'd0, 32'd0, 32'd0, MEM_B, '0, '0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && model_q.size() != 0; i++) idle(1'b1);
        idle(1'b0);
        chk("drain_model_empty", 512'(model_q.size()), 512'd0);
    endtask

    // Monitor: per-cycle handshake/rollback checks and in-order dequeue scoreboard.
    initial begin
        cyc_t        c;
        logic [511:0] ed, bm;
        logic [63:0]  ee;
        mentry_t      e;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                c = cyc_q.pop_front();
                chk("valid", 512'(sq_l2_req_valid), 512'(c.valid));
                chk("empty", 512'(sq_empty), 512'(!c.valid));
                chk("rollback_en", 512'(sq_rollback_en), 512'(c.rb));
                chk("rollback_thread", 512'(sq_rollback_thread_idx), 512'(c.thread));
                chk("rollback_pc", 512'(sq_rollback_pc), 512'(c.pc));
                if (c.valid && l2_sq_req_ready) begin
                    if (deq_q.size() == 0) begin
                        chk("dequeue_expected", 512'd0, 512'd1);
                    end else begin
                        e = deq_q.pop_front();
                        to_dut(e, ed, ee, bm);
                        chk("head_thread", 512'(sq_l2_req_thread_idx), 512'(e.thread));
                        chk("head_line", 512'(sq_l2_req_line_addr), 512'(e.line));
                        chk("head_byte_en", 512'(sq_l2_req_byte_en), 512'(ee));
                        chk("head_data", sq_l2_req_data & bm, ed & bm);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        fmtc_op_t     ops[8] = '{MEM_B, MEM_BX, MEM_S, MEM_SX, MEM_L,
                                 MEM_BLOCK, MEM_BLOCK_M, MEM_BLOCK_IM};
        fmtc_op_t     op;
        logic [31:0]  addr;
        logic [511:0] val;

        #2 reset = 1'b1;
        #2;
        chk("reset_valid", 512'(sq_l2_req_valid), 512'd0);
        chk("reset_empty", 512'(sq_empty), 512'd1);
        @(posedge clk);
        #1 reset = 1'b0;

        // Byte store, then a same-line merge with ready low.
        step(1'b1, 2'd1, 32'h100, 32'h1005, MEM_B, 512'hAB, '0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("byte_valid", 512'(sq_l2_req_valid), 512'd1);
        chk("byte_line", 512'(sq_l2_req_line_addr), 512'h40);
        chk("byte_en", 512'(sq_l2_req_byte_en), 512'h0400_0000_0000_0000);
        chk("byte_data", 512'(sq_l2_req_data[471:464]), 512'hAB);
        step(1'b1, 2'd1, 32'h104, 32'h1006, MEM_B, 512'hCD, '0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("merge_byte_en", 512'(sq_l2_req_byte_en), 512'h0600_0000_0000_0000);
        chk("merge_data", 512'(sq_l2_req_data[471:456]), 512'hABCD);
        drain();

        step(1'b1, 2'd0, 32'h200, 32'h1002, MEM_S, 512'h1234, '0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("half_data", 512'(sq_l2_req_data[495:480]), 512'h3412);
        chk("half_byte_en", 512'(sq_l2_req_byte_en), 512'h3000_0000_0000_0000);
        drain();

        step(1'b1, 2'd0, 32'h204, 32'h1000, MEM_L, 512'hDEADBEEF, '0, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("word_data", 512'(sq_l2_req_data[511:480]), 512'hEFBEADDE);
        chk("word_byte_en", 512'(sq_l2_req_byte_en), 512'hF000_0000_0000_0000);
        drain();

        step(1'b1, 2'd2, 32'h208, 32'h1000, MEM_BLOCK, 512'h11223344, 16'h0001, 1'b0);
        idle(1'b0);
        @(negedge clk);
        chk("block_data", 512'(sq_l2_req_data[31:0]), 512'h44332211);
        chk("block_byte_en", 512'(sq_l2_req_byte_en), 512'h000F);
        drain();

        // Single entry leaving while a same-line store arrives: no merge.
        step(1'b1, 2'd1, 32'h300, 32'h1005, MEM_B, 512'hAB, '0, 1'b0);
        step(1'b1, 2'd1, 32'h304, 32'h1006, MEM_B, 512'hCD, '0, 1'b1);
        idle(1'b0);
        @(negedge clk);
        chk("nomerge_byte_en", 512'(sq_l2_req_byte_en), 512'h0200_0000_0000_0000);
        drain();

        // Full queue: fifth store rejected, then accepted when a dequeue coincides.
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'(i), 32'h400 + 32'(i*4), 32'h2000 + 32'(i*64), MEM_L, 512'(i), '0, 1'b0);
        step(1'b1, 2'd3, 32'h4F0, 32'h3000, MEM_L, 512'h55, '0, 1'b0);
        @(negedge clk);
        chk("full_rollback_en", 512'(sq_rollback_en), 512'd1);
        chk("full_rollback_pc", 512'(sq_rollback_pc), 512'h4F0);
        chk("full_rollback_thread", 512'(sq_rollback_thread_idx), 512'd3);
        drain();
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'(i), 32'h500 + 32'(i*4), 32'h2000 + 32'(i*64), MEM_L, 512'(i), '0, 1'b0);
        step(1'b1, 2'd3, 32'h5F0, 32'h3000, MEM_L, 512'h66, '0, 1'b1);
        @(negedge clk);
        chk("full_ready_no_rollback", 512'(sq_rollback_en), 512'd0);
        drain();

        // Ten back-to-back enqueue/dequeue cycles wrap both pointers.
        for (int i = 0; i < 10; i++)
            step(1'b1, 2'd0, 32'h600 + 32'(i), 32'h4000 + 32'(i*64), MEM_B, 512'(i + 16), '0, 1'b1);
        drain();

        // Reset with three entries pending.
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'd1, 32'h700, 32'h5000 + 32'(i*64), MEM_B, 512'(i), '0, 1'b0);
        @(posedge clk);
        #1;
        dd_store_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset_valid", 512'(sq_l2_req_valid), 512'd0);
        chk("midreset_empty", 512'(sq_empty), 512'd1);
        model_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomized traffic over a few lines and threads so merges are common.
        for (int cyc = 0; cyc < 600; cyc++) begin
            op = ops[$urandom_range(7)];
            addr = {26'h40 + 26'($urandom_range(2)), 6'($urandom)};
            if (op == MEM_S || op == MEM_SX) addr[0] = 1'b0;
            if (op == MEM_L) addr[1:0] = 2'b00;
            if (op == MEM_BLOCK || op == MEM_BLOCK_M || op == MEM_BLOCK_IM) addr[5:0] = '0;
            for (int w = 0; w < 16; w++) val[w*32 +: 32] = $urandom;
            step($urandom_range(9) < 7, 2'($urandom_range(1)), $urandom, addr, op, val,
                 16'($urandom), $urandom_range(2) == 0);
        end
        drain();
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 512'(deq_q.size() + cyc_q.size()), 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
